// File: rtl/vga_sync.sv
`timescale 1ns/1ps
// vga_sync: 640x480@60Hz VGA timing generator driven from the system clock.
// A clk/CLK_DIV divider produces p_tick once per pixel; x/y walk the full
// H_TOTAL x V_TOTAL raster. hsync/vsync are registered from the next-state
// counters so they change on the same edge as x/y.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-low reset
//   hsync       out  horizontal sync, active-low, registered
//   vsync       out  vertical sync, active-low, registered
//   video_on    out  1 while x/y lie in the visible area (combinational)
//   p_tick      out  one-clk pulse per pixel (div == CLK_DIV-1)
//   x           out  current column, 0..H_TOTAL-1, registered
//   y           out  current line, 0..V_TOTAL-1, registered
//   frame_tick  out  one-clk pulse per frame on the first clk of x=0,
//                    y=V_DISPLAY+1; present only when VGA_SYNC_FRAME_TICK_EN
//                    is defined
module vga_sync #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y
`ifdef VGA_SYNC_FRAME_TICK_EN
  ,
  output logic       frame_tick
`endif
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div;
  logic [9:0]       x_next;
  logic [9:0]       y_next;

  always_comb begin
    p_tick = (div == DIV_LAST);
  end

  always_comb begin
    video_on = (x < X_VIS) && (y < Y_VIS);
  end

  always_comb begin
    x_next = x;
    y_next = y;
    if (p_tick) begin
      if (x == X_LAST) begin
        x_next = '0;
        y_next = (y == Y_LAST) ? '0 : y + 10'd1;
      end else begin
        x_next = x + 10'd1;
      end
    end
  end

  // Syncs decode x_next/y_next so they land on the same edge as x/y.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div   <= '0;
      x     <= '0;
      y     <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      div   <= p_tick ? '0 : div + DIV_W'(1);
      x     <= x_next;
      y     <= y_next;
      hsync <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
      vsync <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
    end
  end

`ifdef VGA_SYNC_FRAME_TICK_EN
  localparam logic [9:0] FT_Y = 10'(V_DISPLAY + 1);

  // Only a p_tick edge can move onto (0, FT_Y), so the pulse is one clk wide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= p_tick && (x_next == '0) && (y_next == FT_Y);
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync.sv
`timescale 1ns/1ps
module tb_vga_sync;

  logic clk       = 1'b0;
  logic rst_big   = 1'b1;
  logic rst_small = 1'b1;

  logic       hs_b, vs_b, von_b, pt_b;
  logic [9:0] x_b, y_b;
  logic       hs_s, vs_s, von_s, pt_s;
  logic [9:0] x_s, y_s;
`ifdef VGA_SYNC_FRAME_TICK_EN
  logic       ft_b, ft_s;
`endif

  always #5 clk = ~clk;

  vga_sync u_big (
    .clk(clk), .reset(rst_big), .hsync(hs_b), .vsync(vs_b),
    .video_on(von_b), .p_tick(pt_b), .x(x_b), .y(y_b)
`ifdef VGA_SYNC_FRAME_TICK_EN
    , .frame_tick(ft_b)
`endif
  );

  // Miniature raster: H 8/2/3/2 (15), V 6/1/2/2 (11), 2 clks per pixel.
  vga_sync #(
    .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) u_small (
    .clk(clk), .reset(rst_small), .hsync(hs_s), .vsync(vs_s),
    .video_on(von_s), .p_tick(pt_s), .x(x_s), .y(y_s)
`ifdef VGA_SYNC_FRAME_TICK_EN
    , .frame_tick(ft_s)
`endif
  );

  typedef struct {
    int unsigned dut;
    bit          in_rst;
    int unsigned k;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs, vs, von, pt, ft;
    int          ftc;
  } exp_t;

  exp_t q[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned k_big = 0;
  int unsigned k_small = 0;
  int          ftc_small = 0;

  task automatic push(input int unsigned dut, input bit in_rst, input int unsigned k,
                      input int ex, input int ey, input logic hs, input logic vs,
                      input logic von, input logic pt, input logic ft, input int ftc);
    exp_t e;
    e.dut = dut; e.in_rst = in_rst; e.k = k;
    e.x = 10'(ex); e.y = 10'(ey);
    e.hs = hs; e.vs = vs; e.von = von; e.pt = pt; e.ft = ft; e.ftc = ftc;
    q.push_back(e);
  endtask

  task automatic wait_q(input int unsigned limit);
    for (int unsigned i = 0; i < limit && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      $display("FAIL timeout: %0d vectors still pending, want 0", q.size());
      $fatal(1, "scoreboard stalled");
    end
  endtask

  // Clocks since reset release, one counter per instance.
  always @(posedge clk) begin
    k_big   <= rst_big   ? k_big + 1   : 0;
    k_small <= rst_small ? k_small + 1 : 0;
  end

  // Monitor: pops the head vector when its instance reaches the stated clk.
  always @(negedge clk) begin
    exp_t        e;
    logic        rs, ahs, avs, avon, apt, aft;
    logic [9:0]  ax, ay;
    int unsigned kk;
    bit          bad;
    if (!rst_small) ftc_small = 0;
`ifdef VGA_SYNC_FRAME_TICK_EN
    else if (ft_s) ftc_small = ftc_small + 1;
`endif
    if (q.size() != 0) begin
      e = q[0];
      aft = 1'b0;
      if (e.dut == 0) begin
        rs = rst_big; kk = k_big; ax = x_b; ay = y_b;
        ahs = hs_b; avs = vs_b; avon = von_b; apt = pt_b;
`ifdef VGA_SYNC_FRAME_TICK_EN
        aft = ft_b;
`endif
      end else begin
        rs = rst_small; kk = k_small; ax = x_s; ay = y_s;
        ahs = hs_s; avs = vs_s; avon = von_s; apt = pt_s;
`ifdef VGA_SYNC_FRAME_TICK_EN
        aft = ft_s;
`endif
      end
      if (e.in_rst ? !rs : (rs && kk >= e.k)) begin
        void'(q.pop_front());
        n_vec++;
        bad = (!e.in_rst && kk != e.k) || ax !== e.x || ay !== e.y ||
              ahs !== e.hs || avs !== e.vs || avon !== e.von || apt !== e.pt;
`ifdef VGA_SYNC_FRAME_TICK_EN
        if (aft !== e.ft) bad = 1'b1;
        if (e.ftc >= 0 && e.dut == 1 && ftc_small != e.ftc) bad = 1'b1;
`endif
        if (bad) begin
          n_bad++;
          $display("FAIL dut%0d rst=%0d k=%0d: got k=%0d x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ft=%b ftc=%0d, want x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ft=%b ftc=%0d",
                   e.dut, e.in_rst, e.k, kk, ax, ay, ahs, avs, avon, apt, aft, ftc_small,
                   e.x, e.y, e.hs, e.vs, e.von, e.pt, e.ft, e.ftc);
        end
      end
    end
  end

  initial begin
    #1;
    rst_big = 1'b0;
    rst_small = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    push(0, 1, 0, 0, 0, 1, 1, 1, 0, 0, -1);
    push(1, 1, 0, 0, 0, 1, 1, 1, 0, 0, -1);
    repeat (3) @(posedge clk);
    #1;

    // Full-size raster: first pixel, hsync window, visible edge, line wrap.
    //        dut rst k     x    y  hs vs von pt ft ftc
    push(0, 0, 0,    0,   0, 1, 1, 1, 0, 0, -1);
    push(0, 0, 3,    0,   0, 1, 1, 1, 1, 0, -1);
    push(0, 0, 4,    1,   0, 1, 1, 1, 0, 0, -1);
    push(0, 0, 7,    1,   0, 1, 1, 1, 1, 0, -1);
    push(0, 0, 2556, 639, 0, 1, 1, 1, 0, 0, -1);
    push(0, 0, 2559, 639, 0, 1, 1, 1, 1, 0, -1);
    push(0, 0, 2560, 640, 0, 1, 1, 0, 0, 0, -1);
    push(0, 0, 2623, 655, 0, 1, 1, 0, 1, 0, -1);
    push(0, 0, 2624, 656, 0, 0, 1, 0, 0, 0, -1);
    push(0, 0, 3007, 751, 0, 0, 1, 0, 1, 0, -1);
    push(0, 0, 3008, 752, 0, 1, 1, 0, 0, 0, -1);
    push(0, 0, 3199, 799, 0, 1, 1, 0, 1, 0, -1);
    push(0, 0, 3200, 0,   1, 1, 1, 1, 0, 0, -1);
    push(0, 0, 6400, 0,   2, 1, 1, 1, 0, 0, -1);
    rst_big = 1'b1;
    wait_q(8000);

    // Miniature raster: whole frames, vsync window, frame wrap, frame_tick.
    @(posedge clk);
    #1;
    push(1, 0, 0,    0,  0, 1, 1, 1, 0, 0, -1);
    push(1, 0, 1,    0,  0, 1, 1, 1, 1, 0, -1);
    push(1, 0, 2,    1,  0, 1, 1, 1, 0, 0, -1);
    push(1, 0, 15,   7,  0, 1, 1, 1, 1, 0, -1);
    push(1, 0, 16,   8,  0, 1, 1, 0, 0, 0, -1);
    push(1, 0, 19,   9,  0, 1, 1, 0, 1, 0, -1);
    push(1, 0, 20,   10, 0, 0, 1, 0, 0, 0, -1);
    push(1, 0, 25,   12, 0, 0, 1, 0, 1, 0, -1);
    push(1, 0, 26,   13, 0, 1, 1, 0, 0, 0, -1);
    push(1, 0, 29,   14, 0, 1, 1, 0, 1, 0, -1);
    push(1, 0, 30,   0,  1, 1, 1, 1, 0, 0, -1);
    push(1, 0, 180,  0,  6, 1, 1, 0, 0, 0, -1);
    push(1, 0, 209,  14, 6, 1, 1, 0, 1, 0, -1);
    push(1, 0, 210,  0,  7, 1, 0, 0, 0, 1, 1);
    push(1, 0, 211,  0,  7, 1, 0, 0, 1, 0, 1);
    push(1, 0, 240,  0,  8, 1, 0, 0, 0, 0, -1);
    push(1, 0, 270,  0,  9, 1, 1, 0, 0, 0, -1);
    push(1, 0, 329,  14, 10, 1, 1, 0, 1, 0, -1);
    push(1, 0, 330,  0,  0, 1, 1, 1, 0, 0, -1);
    push(1, 0, 540,  0,  7, 1, 0, 0, 0, 1, 2);
    push(1, 0, 660,  0,  0, 1, 1, 1, 0, 0, -1);
    push(1, 0, 1000, 5,  0, 1, 1, 1, 0, 0, 3);
    rst_small = 1'b1;
    wait_q(1500);

    // Mid-frame reset (x=10, y=3) for one clk, then timing restarts from (0,0).
    while (k_small < 1100) begin
      @(posedge clk);
      #1;
    end
    push(1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    rst_small = 1'b0;
    push(1, 0, 0,   0,  0, 1, 1, 1, 0, 0, 0);
    push(1, 0, 1,   0,  0, 1, 1, 1, 1, 0, -1);
    push(1, 0, 20,  10, 0, 0, 1, 0, 0, 0, -1);
    push(1, 0, 30,  0,  1, 1, 1, 1, 0, 0, -1);
    push(1, 0, 210, 0,  7, 1, 0, 0, 0, 1, 1);
    push(1, 0, 330, 0,  0, 1, 1, 1, 0, 0, -1);
    push(1, 0, 400, 5,  2, 1, 1, 1, 0, 0, 1);
    @(posedge clk);
    #1;
    rst_small = 1'b1;
    wait_q(600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
